// File: rtl/priority_code_pulser.sv
// Receive side of a priority-encoder link: decodes an accepted code into a one-hot
// pulse of fixed width, follows it with a quiet gap, and counts issued pulses.
module priority_code_pulser #(
    parameter int CODE_W    = 2,
    parameter int N         = 4,
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N-1:0]      out_onehot,
    output logic              busy,
    output logic              err_code,
    output logic [CNT_W-1:0]  event_cnt
);

    localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]     PULSE_INIT = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0]     GAP_INIT   = TW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [CODE_W:0]   N_L        = (CODE_W + 1)'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CODE_W-1:0]  code_q,  code_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic accept;
    logic in_range;

    assign in_ready = !rst && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign in_range = ({1'b0, in_code} < N_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        code_d  = code_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_d = HOLD;
                        timer_d = PULSE_INIT;
                        code_d  = in_code;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (timer_q == '0) begin
                    if (GAP_LEN > 0) begin
                        state_d = GAP;
                        timer_d = GAP_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded from the state register so an async reset clears the line immediately.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_line
            assign out_onehot[gi] = (state_q == HOLD) && (code_q == CODE_W'(gi));
        end
    endgenerate

    assign busy      = (state_q != IDLE);
    assign err_code  = err_q;
    assign event_cnt = cnt_q;

endmodule

// File: tb/tb_priority_code_pulser.sv
// Randomized scoreboard bench for priority_code_pulser (N=3 so out-of-range codes
// occur, small counter so saturation is reached).
module tb_priority_code_pulser;

    localparam int CODE_W = 2;
    localparam int N      = 3;
    localparam int P      = 3;
    localparam int G      = 2;
    localparam int CW     = 3;
    localparam int CMAX   = (1 << CW) - 1;

    logic              clk;
    logic              rst;
    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      out_onehot;
    logic              busy;
    logic              err_code;
    logic [CW-1:0]     event_cnt;

    priority_code_pulser #(
        .CODE_W(CODE_W), .N(N), .PULSE_LEN(P), .GAP_LEN(G), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready), .out_onehot(out_onehot), .busy(busy),
        .err_code(err_code), .event_cnt(event_cnt)
    );

    typedef struct {
        int           cyc;
        logic         err;
        logic [N-1:0] oh;
        int           cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a pulse starts or an error flag appears.
    initial begin : monitor
        logic [N-1:0] prev_oh;
        exp_t         e;
        prev_oh = '0;
        forever begin
            @(negedge clk);
            if (!rst && ((out_onehot != '0 && prev_oh == '0) || err_code)) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d got oh=%b err=%b cnt=%0d expected none",
                             cyc, out_onehot, err_code, event_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (e.cyc != cyc || e.err !== err_code || e.oh !== out_onehot
                        || e.cnt != int'(event_cnt)) begin
                        errors++;
                        $display("FAIL txn cyc=%0d got oh=%b err=%b cnt=%0d expected cyc=%0d oh=%b err=%b cnt=%0d",
                                 cyc, out_onehot, err_code, event_cnt, e.cyc, e.oh, e.err, e.cnt);
                    end else begin
                        $display("txn cyc=%0d oh=%b err=%b cnt=%0d ok", cyc, out_onehot, err_code, event_cnt);
                    end
                end
            end
            prev_oh = out_onehot;
        end
    end

    // Reference model: a pulse accepted in cycle c occupies lines c+1..c+P,
    // is quiet c+P+1..c+P+G, and the block is ready again from c+P+G+1.
    initial begin : driver
        int           c;
        int           free_cyc, hold_from, hold_to, gap_to, cnt_m;
        logic [N-1:0] line;
        logic         did_reset;
        logic         exp_ready;
        logic [N-1:0] exp_oh;
        int           code;

        rst = 1'b1; in_valid = 1'b0; in_code = '0;
        #1;
        chk("rst_ready",  in_ready,   0);
        chk("rst_onehot", out_onehot, 0);
        chk("rst_busy",   busy,       0);
        chk("rst_err",    err_code,   0);
        chk("rst_cnt",    event_cnt,  0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        free_cyc = 0; hold_from = 1; hold_to = 0; gap_to = 0; cnt_m = 0;
        line = '0; did_reset = 1'b0;

        for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            c = cyc;
            exp_ready = !rst && (c >= free_cyc);
            exp_oh    = (c >= hold_from && c <= hold_to) ? line : '0;
            chk("in_ready",   in_ready,   exp_ready);
            chk("out_onehot", out_onehot, exp_oh);
            chk("busy",       busy,       (c >= hold_from && c <= gap_to));
            chk("event_cnt",  event_cnt,  cnt_m);

            if (rst) begin
                rst = 1'b0;
            end else if (!did_reset && k > 900 && c >= hold_from && c <= hold_to) begin
                #2 rst = 1'b1;
                in_valid = 1'b0;
                #1;
                chk("async_onehot", out_onehot, 0);
                chk("async_busy",   busy,       0);
                chk("async_cnt",    event_cnt,  0);
                chk("async_ready",  in_ready,   0);
                free_cyc = 0; hold_from = 1; hold_to = 0; gap_to = 0; cnt_m = 0;
                did_reset = 1'b1;
                continue;
            end

            if (k == 10) begin
                in_valid = 1'b1; code = 2;
            end else if (k >= 30 && k < 90) begin
                in_valid = 1'b1; code = 2;
            end else if (k >= 90 && k < 100) begin
                in_valid = 1'b1; code = 3;
            end else if (k >= 100) begin
                in_valid = ($urandom_range(0, 3) != 0);
                code     = int'($urandom_range(0, 3));
            end else begin
                in_valid = 1'b0; code = int'($urandom_range(0, 3));
            end
            in_code = CODE_W'(code);

            if (in_valid && c >= free_cyc) begin
                if (code < N) begin
                    line      = '0;
                    line[code] = 1'b1;
                    hold_from = c + 1;
                    hold_to   = c + P;
                    gap_to    = c + P + G;
                    free_cyc  = c + P + G + 1;
                    if (cnt_m < CMAX) cnt_m++;
                    sb_q.push_back('{cyc: c + 1, err: 1'b0, oh: line, cnt: cnt_m});
                end else begin
                    sb_q.push_back('{cyc: c + 1, err: 1'b1, oh: '0, cnt: cnt_m});
                end
            end
        end

        in_valid = 1'b0;
        repeat (P + G + 3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("reset_exercised", did_reset, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
